// File: rtl/add_seq_pkg.sv
// Shared types and constants for the polynomial-adder sequencer.
// Optional stall counter in add_seq_ctrl is enabled by defining ADD_SEQ_PERF_EN.
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned ADD_K      = 3;
  localparam int unsigned SEL_Y_E2   = 0;
  localparam int unsigned SEL_U_BASE = 1;
  localparam int unsigned SEL_V      = ADD_K + 1;
  localparam int unsigned STALL_W    = 16;

endpackage

// File: rtl/add_seq_stall_cnt.sv
// Saturating stall counter with synchronous clear; clear wins over increment.
module add_seq_stall_cnt
  import add_seq_pkg::*;
#(
  parameter int unsigned W = STALL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/add_seq_ctrl.sv
// Sequencer stepping the shared adder array through K+2 passes (temp, u[0..K-1], v).
// Define ADD_SEQ_PERF_EN to build the stall_cnt counter; otherwise stall_cnt is tied to zero.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int unsigned K     = ADD_K,
  parameter int unsigned SEL_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [K+1:0]       op_rdy,
  output logic [SEL_W-1:0]   sel,
  output logic               cap_tmp,
  output logic [K-1:0]       cap_u,
  output logic               cap_v,
  output logic               busy,
  output logic               done,
  output logic               err_busy,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(SEL_Y_E2);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(K + 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             err_busy_q, err_busy_d;
  logic             rdy_s;
  logic             fire_s;

  // operand-ready for the current pass only; out-of-range idx reads as not ready
  always_comb begin
    rdy_s = 1'b0;
    for (int i = 0; i < int'(K) + 2; i++) begin
      rdy_s = rdy_s | ((idx_q == SEL_W'(i)) & op_rdy[i]);
    end
  end

  // next state, pass index and status outputs
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_busy_d = 1'b0;
    fire_s     = 1'b0;
    sel        = SEL_FIRST;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = PASS;
          idx_d   = SEL_FIRST;
        end else begin
          state_d = IDLE;
        end
      end
      PASS: begin
        busy       = 1'b1;
        sel        = idx_q;
        err_busy_d = start;
        // abort outranks a ready operand: nothing is captured this cycle
        if (abort) begin
          state_d = IDLE;
          idx_d   = SEL_FIRST;
        end else if (rdy_s) begin
          fire_s = 1'b1;
          if (idx_q == SEL_LAST) begin
            state_d = DONE;
            idx_d   = SEL_FIRST;
          end else begin
            idx_d = idx_q + {{(SEL_W-1){1'b0}}, 1'b1};
          end
        end else begin
          idx_d = idx_q;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = !abort;
        err_busy_d = start;
        state_d    = IDLE;
        idx_d      = SEL_FIRST;
      end
      default: begin
        state_d = IDLE;
        idx_d   = SEL_FIRST;
      end
    endcase
  end

  // one-hot capture strobe decode; datapath captures on the same edge
  always_comb begin
    cap_tmp = fire_s & (idx_q == SEL_FIRST);
    cap_v   = fire_s & (idx_q == SEL_LAST);
    cap_u   = '0;
    for (int i = 0; i < int'(K); i++) begin
      cap_u[i] = fire_s & (idx_q == SEL_W'(SEL_U_BASE + i));
    end
  end

  // state, pass index and err_busy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      err_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_busy_q <= err_busy_d;
    end
  end

  assign err_busy = err_busy_q;

`ifdef ADD_SEQ_PERF_EN
  logic stall_inc_s;
  logic stall_clr_s;

  assign stall_inc_s = (state_q == PASS) && !rdy_s;
  assign stall_clr_s = (state_q == IDLE) && start && !abort;

  add_seq_stall_cnt #(
    .W(STALL_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (stall_clr_s),
    .inc  (stall_inc_s),
    .cnt  (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (K=3): nominal run, stall, start-while-busy, abort, async reset.
module tb_add_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [4:0]  op_rdy;
  logic [2:0]  sel;
  logic        cap_tmp;
  logic [2:0]  cap_u;
  logic        cap_v;
  logic        busy;
  logic        done;
  logic        err_busy;
  logic [15:0] stall_cnt;

  int n_chk;
  int n_bad;

`ifdef ADD_SEQ_PERF_EN
  localparam logic [15:0] EXP_STALL = 16'd4;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  add_seq_ctrl #(.K(3), .SEL_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .op_rdy   (op_rdy),
    .sel      (sel),
    .cap_tmp  (cap_tmp),
    .cap_u    (cap_u),
    .cap_v    (cap_v),
    .busy     (busy),
    .done     (done),
    .err_busy (err_busy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected output word {sel, cap_tmp, cap_u, cap_v, busy, done, err_busy}
  function automatic logic [10:0] ev(input logic [2:0] s, input logic t, input logic [2:0] u,
                                     input logic v, input logic b, input logic d, input logic e);
    return {s, t, u, v, b, d, e};
  endfunction

  function automatic logic [10:0] obs();
    return {sel, cap_tmp, cap_u, cap_v, busy, done, err_busy};
  endfunction

  // one cycle: drive inputs at negedge, check outputs, advance to the next negedge
  task automatic cyc(input string tag, input logic [4:0] rdy, input logic st, input logic ab,
                     input logic [10:0] exp);
    op_rdy = rdy;
    start  = st;
    abort  = ab;
    #1;
    chk(tag, 32'(obs()), 32'(exp));
    @(negedge clk);
  endtask

  localparam logic [10:0] IDL = 11'd0;

  initial begin
    n_chk  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    op_rdy = 5'b00000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", 32'(obs()), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: nominal full sequence
    cyc("t1c0", 5'b11111, 1'b1, 1'b0, IDL);
    cyc("t1c1", 5'b11111, 1'b0, 1'b0, ev(3'd0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t1c2", 5'b11111, 1'b0, 1'b0, ev(3'd1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t1c3", 5'b11111, 1'b0, 1'b0, ev(3'd2, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t1c4", 5'b11111, 1'b0, 1'b0, ev(3'd3, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t1c5", 5'b11111, 1'b0, 1'b0, ev(3'd4, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0));
    cyc("t1c6", 5'b11111, 1'b0, 1'b0, ev(3'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc("t1c7", 5'b11111, 1'b0, 1'b0, IDL);
    chk("t1_stall", 32'(stall_cnt), 32'd0);

    // 2: four-cycle stall on pass 2 (op_rdy[2] low)
    cyc("t2c0", 5'b11111, 1'b1, 1'b0, IDL);
    cyc("t2c1", 5'b11111, 1'b0, 1'b0, ev(3'd0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t2c2", 5'b11111, 1'b0, 1'b0, ev(3'd1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int i = 3; i < 7; i++) begin
      cyc($sformatf("t2c%0d", i), 5'b11011, 1'b0, 1'b0,
          ev(3'd2, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    cyc("t2c7", 5'b11111, 1'b0, 1'b0, ev(3'd2, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t2c8", 5'b11111, 1'b0, 1'b0, ev(3'd3, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t2c9", 5'b11111, 1'b0, 1'b0, ev(3'd4, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0));
    cyc("t2c10", 5'b11111, 1'b0, 1'b0, ev(3'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc("t2c11", 5'b11111, 1'b0, 1'b0, IDL);
    chk("t2_stall", 32'(stall_cnt), 32'(EXP_STALL));
    cyc("t2c12", 5'b11111, 1'b0, 1'b0, IDL);
    chk("t2_stall_hold", 32'(stall_cnt), 32'(EXP_STALL));

    // 3: start while busy in PASS and in DONE -> err_busy next cycle, sequence unchanged
    cyc("t3c0", 5'b11111, 1'b1, 1'b0, IDL);
    cyc("t3c1", 5'b11111, 1'b0, 1'b0, ev(3'd0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t3c2", 5'b11111, 1'b0, 1'b0, ev(3'd1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t3c3", 5'b11111, 1'b1, 1'b0, ev(3'd2, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t3c4", 5'b11111, 1'b0, 1'b0, ev(3'd3, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1));
    cyc("t3c5", 5'b11111, 1'b0, 1'b0, ev(3'd4, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0));
    cyc("t3c6", 5'b11111, 1'b1, 1'b0, ev(3'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc("t3c7", 5'b11111, 1'b0, 1'b0, ev(3'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc("t3c8", 5'b11111, 1'b0, 1'b0, IDL);
    chk("t3_stall_clr", 32'(stall_cnt), 32'd0);

    // 4: abort at pass 3 with its operand ready, then a fresh full sequence
    cyc("t4c0", 5'b11111, 1'b1, 1'b0, IDL);
    cyc("t4c1", 5'b11111, 1'b0, 1'b0, ev(3'd0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t4c2", 5'b11111, 1'b0, 1'b0, ev(3'd1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t4c3", 5'b11111, 1'b0, 1'b0, ev(3'd2, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t4c4", 5'b11111, 1'b0, 1'b1, ev(3'd3, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t4c5", 5'b11111, 1'b0, 1'b0, IDL);
    cyc("t4c6", 5'b11111, 1'b0, 1'b0, IDL);
    cyc("t4sa", 5'b11111, 1'b1, 1'b1, IDL);
    cyc("t4sb", 5'b11111, 1'b0, 1'b0, IDL);
    cyc("t4f0", 5'b11111, 1'b1, 1'b0, IDL);
    cyc("t4f1", 5'b11111, 1'b0, 1'b0, ev(3'd0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t4f2", 5'b11111, 1'b0, 1'b0, ev(3'd1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t4f3", 5'b11111, 1'b0, 1'b0, ev(3'd2, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t4f4", 5'b11111, 1'b0, 1'b0, ev(3'd3, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t4f5", 5'b11111, 1'b0, 1'b0, ev(3'd4, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0));
    cyc("t4f6", 5'b11111, 1'b0, 1'b0, ev(3'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc("t4f7", 5'b11111, 1'b0, 1'b0, IDL);

    // 5: asynchronous reset mid-PASS while a strobe is high
    cyc("t5c0", 5'b11111, 1'b1, 1'b0, IDL);
    cyc("t5c1", 5'b11111, 1'b0, 1'b0, ev(3'd0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("t5c2", 5'b11111, 1'b0, 1'b0, ev(3'd1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
    op_rdy = 5'b11111;
    #1;
    chk("t5_pre", 32'(obs()), 32'(ev(3'd2, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0)));
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async", 32'(obs()), 32'd0);
    chk("t5_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("t5r0", 5'b11111, 1'b0, 1'b0, IDL);
    cyc("t5r1", 5'b11111, 1'b0, 1'b0, IDL);
    cyc("t5r2", 5'b11111, 1'b1, 1'b0, IDL);
    cyc("t5r3", 5'b11111, 1'b0, 1'b0, ev(3'd0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
